output_arbiter: RTL and testbench
=================================

// Module: output_arbiter
// PURPOSE
// - Per-output-port stage directly downstream of the analysers; one instance per output.
// - Collects the one-hot requests that the N analysers raise for this output and grants one input at a time, round-robin.
// - Holds the grant until the packet's last beat, a length limit or a stall abort.
// - While granted, forwards the winner's data byte to the output link with a valid/ready handshake.
// PARAMETERS
// - N          4   number of input ports (analysers) competing for this output
// - DW         8   data beat width (matches analyser data_out)
// - MAX_BEATS  16  max beats per grant; forced release on the 16th accepted beat
// - STALL_MAX  8   consecutive granted cycles with req low before abort
// PORTS
// - clk        in   1     single clock, rising edge
// - reset      in   1     asynchronous, active-low; clears all state immediately
// - req_in     in   N     bit i = analyser i requests this output
// - data_in    in   N*DW  analyser i beat at [i*DW +: DW]
// - last_in    in   N     bit i = current beat of input i ends its packet
// - ready_in   in   1     output link accepts a beat this cycle
// - gnt_out    out  N     registered one-hot grant; all-zero when idle
// - pop_out    out  N     gnt_out & req_in & {N{ready_in}}: input i beat consumed
// - data_out   out  DW    data_in slice of granted input; 0 when no grant
// - valid_out  out  1     |(gnt_out & req_in)
// - last_out   out  1     granted last_in, or forced on the MAX_BEATS-th beat
// - abort_out  out  1     one-cycle pulse on stall abort
// BEHAVIOUR
// - Reset values: gnt_out=0, abort_out=0, state=IDLE, beat_cnt=0, stall_cnt=0, ptr=N-1.
// - Combinational outputs follow from these reset values: data_out=0, valid_out=0, last_out=0, pop_out=0.
// - After reset, input 0 has top priority.
// - FSM IDLE:
//   - If |req_in, pick the first set bit searching from ptr+1 with wrap.
//   - Register the pick in gnt_out and move to TRANS.
//   - First beat can transfer one cycle after the request is seen (1-cycle arbitration latency).
// - FSM TRANS:
//   - Transfer = valid_out & ready_in; each transfer increments beat_cnt.
//   - On a transfer with last_out=1: gnt_out<=0, ptr<=granted index, beat_cnt<=0, go IDLE.
//   - That cycle is the release cycle; the next grant is earliest the following cycle, so there are no back-to-back grants.
//   - last_out=1 when granted last_in=1, or when beat_cnt==MAX_BEATS-1 (forced truncation).
// - Stall handling (granted req_in low):
//   - stall_cnt increments each such cycle; it resets to 0 whenever the granted req_in is high.
//   - When stall_cnt reaches STALL_MAX-1 and req is still low, abort that cycle.
//   - Abort: abort_out pulses for 1 cycle, gnt_out<=0, ptr<=granted index, go IDLE. No beat is emitted.
// - ready_in low: hold state and grant; beat_cnt frozen; stall_cnt unaffected (backpressure is not a stall).
// - Simultaneous release and new requests: release wins; arbitration happens the following IDLE cycle.
// - Requests from non-granted inputs are ignored in TRANS; no pop_out for them.
// - Reset asserted mid-packet: everything clears asynchronously, the packet is dropped, priority restarts at input 0.
// - Counter widths: beat_cnt is $clog2(MAX_BEATS+1), stall_cnt is $clog2(STALL_MAX+1); neither wraps.
// - ptr width is $clog2(N); wrap from N-1 to 0.
// STRUCTURE
// - router_pkg holds:
//   - typedef enum logic {IDLE=0, TRANS=1} arb_state_t
//   - SAP_W=8, DATA_W=8, FLIT_W=24 (shared with analyser)
// - Sub-module rr_pick: purely combinational rotate-priority encoder.
//   - Inputs: req[N], ptr. Output: one-hot gnt[N].
//   - Reused by future multi-output crossbar.
// - Top holds FSM, counters, ptr register, output mux.
// TESTING
// - Reset then req_in=4'b0110, last_in=1, ready_in=1:
//   - gnt_out=0010 next cycle, 1 beat out with last_out=1, IDLE.
//   - Then gnt_out=0100 after 1 idle cycle.
// - All 4 requesting 1-beat packets continuously:
//   - grant order 0,1,2,3,0; each grant separated by exactly 1 idle cycle.
// - Input 2 sends 3 beats 0xA1,0xA2,0xA3 with last on the third; ready_in low on beat 2 for 2 cycles:
//   - data_out holds 0xA2; pop_out=0 during the low cycles.
//   - Exactly 3 pops; last_out only on 0xA3.
// - Input 1 streams 20 beats with last_in never set:
//   - last_out forced on beat 16, gnt released.
//   - Input 1 rearbitrated after the others.
// - Input 3 granted, then req_in[3] drops for 8 cycles:
//   - abort_out pulses once on the 8th cycle, gnt_out=0; no data beats.
// - reset pulsed low mid-packet on input 2:
//   - All outputs 0 immediately; next grant with all requesting goes to input 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types and widths used by the analysers and output arbiters.
package router_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        TRANS = 1'b1
    } arb_state_t;

    localparam int unsigned SAP_W  = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned FLIT_W = 24;

endpackage

// File: rtl/output_arbiter_if.sv
// Analyser-side requests/data plus output-link handshake for one output port.
// master = analysers and link (drive requests, data, ready); slave = arbiter.
interface output_arbiter_if
    import router_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = DATA_W
);

    logic [N-1:0]    req_in;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    last_in;
    logic            ready_in;
    logic [N-1:0]    gnt_out;
    logic [N-1:0]    pop_out;
    logic [DW-1:0]   data_out;
    logic            valid_out;
    logic            last_out;
    logic            abort_out;

    modport master (
        output req_in, data_in, last_in, ready_in,
        input  gnt_out, pop_out, data_out, valid_out, last_out, abort_out
    );

    modport slave (
        input  req_in, data_in, last_in, ready_in,
        output gnt_out, pop_out, data_out, valid_out, last_out, abort_out
    );

endinterface

// File: rtl/rr_pick.sv
// Rotate-priority encoder: one-hot pick of the first set request at or after ptr+1, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic [PW-1:0] idx;
    logic          found;

    // Walk the ring starting just after the last winner; first hit wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr_i) + i + 32'd1) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Per-output round-robin arbiter: grants one analyser at a time and forwards its beats
// to the output link until last beat, beat-count truncation or stall abort.
module output_arbiter
    import router_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned DW        = DATA_W,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned STALL_MAX = 8
) (
    input logic              clk,
    input logic              reset,
    output_arbiter_if.slave  bus
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BW = $clog2(MAX_BEATS + 1);
    localparam int unsigned SW = $clog2(STALL_MAX + 1);
    localparam logic [BW-1:0] BeatLast  = BW'(MAX_BEATS - 1);
    localparam logic [SW-1:0] StallLast = SW'(STALL_MAX - 1);

    arb_state_t    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          abort_q, abort_d;

    logic [N-1:0]  pick;
    logic [N-1:0]  gnt_req;
    logic [PW-1:0] gnt_idx;
    logic [DW-1:0] data_sel;
    logic          last_sel;
    logic          valid;
    logic          last;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_rr_pick (
        .req_i (bus.req_in),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    // Output mux and index encode of the one-hot grant; zero when nothing is granted.
    always_comb begin
        data_sel = '0;
        last_sel = 1'b0;
        gnt_idx  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_q[i]) begin
                data_sel = data_sel | bus.data_in[i*DW +: DW];
                last_sel = last_sel | bus.last_in[i];
                gnt_idx  = PW'(i);
            end
        end
    end

    assign gnt_req = gnt_q & bus.req_in;
    assign valid   = |gnt_req;
    // Truncation forces last on the MAX_BEATS-th beat of a grant.
    assign last    = valid & (last_sel | (beat_q == BeatLast));

    assign bus.gnt_out   = gnt_q;
    assign bus.pop_out   = gnt_req & {N{bus.ready_in}};
    assign bus.data_out  = data_sel;
    assign bus.valid_out = valid;
    assign bus.last_out  = last;
    assign bus.abort_out = abort_q;

    // Next-state: arbitrate in IDLE, count beats/stalls and release in TRANS.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        stall_d = stall_q;
        abort_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|bus.req_in) begin
                    gnt_d   = pick;
                    beat_d  = '0;
                    stall_d = '0;
                    state_d = TRANS;
                end
            end
            TRANS: begin
                if (valid) begin
                    stall_d = '0;
                    // Backpressure freezes beat_cnt and leaves the grant in place.
                    if (bus.ready_in) begin
                        if (last) begin
                            gnt_d   = '0;
                            ptr_d   = gnt_idx;
                            beat_d  = '0;
                            state_d = IDLE;
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end
                end else if (stall_q == StallLast) begin
                    abort_d = 1'b1;
                    gnt_d   = '0;
                    ptr_d   = gnt_idx;
                    beat_d  = '0;
                    stall_d = '0;
                    state_d = IDLE;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
            end
        endcase
    end

    // State registers; reset leaves input 0 with top priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= PW'(N - 1);
            beat_q  <= '0;
            stall_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            stall_q <= stall_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter: vector table plus multi-cycle corner sequences.
module tb_output_arbiter;

    logic clk;
    logic reset;

    int checks;
    int errors;

    output_arbiter_if #(.N(4), .DW(8)) bus ();

    output_arbiter #(
        .N         (4),
        .DW        (8),
        .MAX_BEATS (16),
        .STALL_MAX (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  last;
        logic        rdy;
        logic [3:0]  gnt;
        logic [3:0]  pop;
        logic [7:0]  dout;
        logic        valid;
        logic        lst;
        logic        abort;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic [31:0] data,
                         input logic [3:0] last, input logic rdy);
        bus.req_in   = req;
        bus.data_in  = data;
        bus.last_in  = last;
        bus.ready_in = rdy;
    endtask

    task automatic do_reset();
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, " gnt"},   32'(bus.gnt_out),   32'h0);
        chk({tag, " pop"},   32'(bus.pop_out),   32'h0);
        chk({tag, " data"},  32'(bus.data_out),  32'h0);
        chk({tag, " valid"}, 32'(bus.valid_out), 32'h0);
        chk({tag, " last"},  32'(bus.last_out),  32'h0);
        chk({tag, " abort"}, 32'(bus.abort_out), 32'h0);
    endtask

    initial begin
        logic [3:0] exp_g;
        logic [3:0] tr_gnt [8];
        checks = 0;
        errors = 0;

        // req, data, last, rdy | gnt, pop, dout, valid, last, abort
        vecs[0]  = '{4'b0000, 32'h33221100, 4'b1111, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0110, 32'h33221100, 4'b1111, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'b0110, 32'h33221100, 4'b1111, 1'b1, 4'b0010, 4'b0010, 8'h11, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{4'b0100, 32'h33221100, 4'b1111, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'b0100, 32'h33221100, 4'b1111, 1'b1, 4'b0100, 4'b0100, 8'h22, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{4'b0000, 32'h33221100, 4'b1111, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'b0100, 32'h00A10000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0100, 32'h00A10000, 4'b0000, 1'b1, 4'b0100, 4'b0100, 8'hA1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{4'b0100, 32'h00A20000, 4'b0000, 1'b0, 4'b0100, 4'b0000, 8'hA2, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{4'b0100, 32'h00A20000, 4'b0000, 1'b0, 4'b0100, 4'b0000, 8'hA2, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{4'b0100, 32'h00A20000, 4'b0000, 1'b1, 4'b0100, 4'b0100, 8'hA2, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{4'b0100, 32'h00A30000, 4'b0100, 1'b1, 4'b0100, 4'b0100, 8'hA3, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0};

        tr_gnt = '{4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010};

        // Reset state
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        reset = 1'b0;
        #2;
        chk_idle_outs("reset");
        step();
        step();
        reset = 1'b1;

        // Table: two single-beat packets, then a 3-beat packet with backpressure
        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].req, vecs[k].data, vecs[k].last, vecs[k].rdy);
            @(negedge clk);
            chk($sformatf("v%0d gnt", k),   32'(bus.gnt_out),   32'(vecs[k].gnt));
            chk($sformatf("v%0d pop", k),   32'(bus.pop_out),   32'(vecs[k].pop));
            chk($sformatf("v%0d data", k),  32'(bus.data_out),  32'(vecs[k].dout));
            chk($sformatf("v%0d valid", k), 32'(bus.valid_out), 32'(vecs[k].valid));
            chk($sformatf("v%0d last", k),  32'(bus.last_out),  32'(vecs[k].lst));
            chk($sformatf("v%0d abort", k), 32'(bus.abort_out), 32'(vecs[k].abort));
            step();
        end

        // All four requesting single-beat packets: 0,1,2,3,0 with an idle cycle between
        do_reset();
        drive(4'b1111, 32'h33221100, 4'b1111, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_g = (k % 2 == 1) ? 4'(1 << (((k - 1) / 2) % 4)) : 4'b0000;
            chk($sformatf("rr%0d gnt", k), 32'(bus.gnt_out), 32'(exp_g));
            if (k % 2 == 1) begin
                chk($sformatf("rr%0d data", k), 32'(bus.data_out),
                    32'(((k - 1) / 2) % 4) * 32'h11);
                chk($sformatf("rr%0d last", k), 32'(bus.last_out), 32'h1);
            end
            step();
        end

        // Input 1 streams without last: forced last on the 16th beat, then rearbitrated last
        do_reset();
        drive(4'b0010, 32'h0, 4'b0000, 1'b1);
        @(negedge clk);
        chk("trunc idle gnt", 32'(bus.gnt_out), 32'h0);
        step();
        for (int k = 1; k <= 16; k++) begin
            bus.data_in = 32'(k) << 8;
            @(negedge clk);
            chk($sformatf("trunc b%0d pop", k),  32'(bus.pop_out),  32'h2);
            chk($sformatf("trunc b%0d data", k), 32'(bus.data_out), 32'(k));
            chk($sformatf("trunc b%0d last", k), 32'(bus.last_out), 32'(k == 16));
            step();
        end
        drive(4'b1111, 32'h33221100, 4'b1101, 1'b1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk($sformatf("trunc rr%0d gnt", j), 32'(bus.gnt_out), 32'(tr_gnt[j]));
            step();
        end

        // Input 3 granted, then its request drops: one abort pulse, no beats
        do_reset();
        drive(4'b1000, 32'h44000000, 4'b0000, 1'b1);
        @(negedge clk);
        chk("abort idle gnt", 32'(bus.gnt_out), 32'h0);
        step();
        bus.req_in = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("abort c%0d valid", k), 32'(bus.valid_out), 32'h0);
            chk($sformatf("abort c%0d pulse", k), 32'(bus.abort_out), 32'(k == 9));
            chk($sformatf("abort c%0d gnt", k),   32'(bus.gnt_out),   (k <= 8) ? 32'h8 : 32'h0);
            step();
        end

        // Asynchronous reset mid-packet on input 2, then priority restarts at input 0
        do_reset();
        drive(4'b0100, 32'h00550000, 4'b0000, 1'b1);
        step();
        @(negedge clk);
        chk("rst pre gnt", 32'(bus.gnt_out), 32'h4);
        step();
        reset = 1'b0;
        #1;
        chk_idle_outs("rst async");
        @(negedge clk);
        reset = 1'b1;
        drive(4'b1111, 32'h33221100, 4'b1111, 1'b1);
        step();
        @(negedge clk);
        chk("rst post gnt", 32'(bus.gnt_out), 32'h1);
        chk("rst post data", 32'(bus.data_out), 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
